// File: rtl/accel_i2c_pkg.sv
// Shared types and constants for the accelerometer I2C configuration/polling sequencer.
package accel_i2c_pkg;

  localparam logic [6:0] ACCEL_DEV_ADDR = 7'h53;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_CFG_NEXT,
    ST_RUN,
    ST_POLL_ISSUE,
    ST_POLL_WAIT,
    ST_FAIL,
    ST_CFG_VERIFY,
    ST_CFG_VWAIT
  } seq_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  // Standby, 16g full-res, 100 Hz, no interrupts, FIFO bypass, X offset, then measure.
  localparam int DEFAULT_CFG_LEN = 8;
  localparam cfg_entry_t DEFAULT_CFG_TABLE [DEFAULT_CFG_LEN] = '{
    '{addr: 8'h2D, data: 8'h00},
    '{addr: 8'h31, data: 8'h0B},
    '{addr: 8'h2C, data: 8'h0A},
    '{addr: 8'h2E, data: 8'h00},
    '{addr: 8'h2F, data: 8'h00},
    '{addr: 8'h38, data: 8'h00},
    '{addr: 8'h1E, data: 8'h05},
    '{addr: 8'h2D, data: 8'h08}
  };

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/accel_cfg_rom.sv
// Combinational configuration table lookup; replace this file to change the per-board register set.
module accel_cfg_rom
  import accel_i2c_pkg::*;
(
  input  logic [3:0] idx,
  output cfg_entry_t entry
);

  always_comb begin
    entry = '0;
    if (int'(idx) < DEFAULT_CFG_LEN) entry = DEFAULT_CFG_TABLE[idx[2:0]];
  end

endmodule

// File: rtl/accel_cfg_seq.sv
// Accelerometer configuration and polling sequencer in front of the I2C master.
// Optional build macro ACCEL_CFG_READBACK_EN: read back and verify every configuration write.
module accel_cfg_seq
  import accel_i2c_pkg::*;
#(
  parameter int         NUM_REGS  = 8,
  parameter int         MAX_RETRY = 3,
  parameter int         POLL_DIV  = 25000,
  parameter logic [7:0] POLL_BASE = 8'h32,
  parameter int         POLL_LEN  = 6
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       configure_en,
  output logic       i2c_req,
  output logic       i2c_rw,
  output logic [6:0] i2c_dev_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  input  logic [7:0] i2c_rdata,
  output logic       cfg_done,
  output logic       cfg_fail,
  output logic [7:0] error_cnt,
  output logic       sample_valid,
  output logic [2:0] sample_idx,
  output logic [7:0] sample_data
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(POLL_DIV + 1);
  localparam logic [3:0]    LAST_ENTRY  = 4'(NUM_REGS - 1);
  localparam logic [2:0]    LAST_BYTE   = 3'(POLL_LEN - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(POLL_DIV - 1);

  seq_state_t    state, state_d;
  logic [3:0]    entry_idx, entry_d;
  logic [RW-1:0] retry_cnt, retry_d;
  logic [2:0]    poll_idx, poll_idx_d;
  logic [TW-1:0] timer, timer_d;
  logic          pend, pend_d;
  logic          cfg_done_d, cfg_fail_d;
  logic [7:0]    err_d;
  logic          rw_d;
  logic [7:0]    addr_d, wdata_d;
  logic          sv_d;
  logic [2:0]    sidx_d;
  logic [7:0]    sdata_d;
  logic          cfg_en_q, cfg_en_prev;
  logic          cfg_rise, tick, restart, attempt_fail;
  cfg_entry_t    entry;

  accel_cfg_rom u_rom (
    .idx   (entry_idx),
    .entry (entry)
  );

  assign cfg_rise     = cfg_en_q & ~cfg_en_prev;
  assign tick         = cfg_done && (timer == TIMER_LAST);
  assign i2c_req      = (state == ST_CFG_WAIT) || (state == ST_POLL_WAIT) || (state == ST_CFG_VWAIT);
  assign i2c_dev_addr = ACCEL_DEV_ADDR;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d      = state;
    entry_d      = entry_idx;
    retry_d      = retry_cnt;
    poll_idx_d   = poll_idx;
    pend_d       = pend;
    cfg_done_d   = cfg_done;
    cfg_fail_d   = cfg_fail;
    err_d        = error_cnt;
    rw_d         = i2c_rw;
    addr_d       = i2c_reg_addr;
    wdata_d      = i2c_wdata;
    sv_d         = 1'b0;
    sidx_d       = sample_idx;
    sdata_d      = sample_data;
    restart      = 1'b0;
    attempt_fail = 1'b0;

    unique case (state)
      ST_IDLE: if (cfg_rise) restart = 1'b1;
      ST_CFG_ISSUE: begin
        rw_d    = 1'b0;
        addr_d  = entry.addr;
        wdata_d = entry.data;
        state_d = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        if (i2c_done && i2c_nack) attempt_fail = 1'b1;
`ifdef ACCEL_CFG_READBACK_EN
        else if (i2c_done) state_d = ST_CFG_VERIFY;
`else
        else if (i2c_done) state_d = ST_CFG_NEXT;
`endif
      end
`ifdef ACCEL_CFG_READBACK_EN
      ST_CFG_VERIFY: begin
        rw_d    = 1'b1;
        state_d = ST_CFG_VWAIT;
      end
      ST_CFG_VWAIT: begin
        if (i2c_done && (i2c_nack || (i2c_rdata != entry.data))) attempt_fail = 1'b1;
        else if (i2c_done) state_d = ST_CFG_NEXT;
      end
`endif
      ST_CFG_NEXT: begin
        if (entry_idx == LAST_ENTRY) begin
          cfg_done_d = 1'b1;
          state_d    = ST_RUN;
        end else begin
          entry_d = entry_idx + 4'd1;
          retry_d = '0;
          state_d = ST_CFG_ISSUE;
        end
      end
      ST_RUN: begin
        if (cfg_rise || pend) restart = 1'b1;
        else if (tick) begin
          poll_idx_d = '0;
          state_d    = ST_POLL_ISSUE;
        end
      end
      ST_POLL_ISSUE: begin
        rw_d    = 1'b1;
        addr_d  = POLL_BASE + {5'd0, poll_idx};
        wdata_d = '0;
        state_d = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (i2c_done && i2c_nack) begin
          err_d   = sat_inc8(error_cnt);
          state_d = ST_RUN;
        end else if (i2c_done) begin
          sv_d    = 1'b1;
          sidx_d  = poll_idx;
          sdata_d = i2c_rdata;
          if (poll_idx == LAST_BYTE) state_d = ST_RUN;
          else begin
            poll_idx_d = poll_idx + 3'd1;
            state_d    = ST_POLL_ISSUE;
          end
        end
      end
      ST_FAIL: if (cfg_rise || pend) restart = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // A failed attempt (NACK, or bad readback) reissues the same write until retries run out.
    if (attempt_fail) begin
      err_d = sat_inc8(error_cnt);
      if (retry_cnt < RETRY_LIMIT) begin
        retry_d = retry_cnt + RW'(1);
        state_d = ST_CFG_ISSUE;
      end else begin
        cfg_fail_d = 1'b1;
        state_d    = ST_FAIL;
      end
    end

    if (restart) begin
      state_d    = ST_CFG_ISSUE;
      entry_d    = '0;
      retry_d    = '0;
      cfg_done_d = 1'b0;
      cfg_fail_d = 1'b0;
      pend_d     = 1'b0;
    end else if (cfg_rise && !(state inside {ST_IDLE, ST_RUN, ST_FAIL})) begin
      pend_d = 1'b1;
    end

    timer_d = '0;
    if (cfg_done) timer_d = tick ? '0 : timer + TW'(1);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      entry_idx    <= '0;
      retry_cnt    <= '0;
      poll_idx     <= '0;
      timer        <= '0;
      pend         <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_fail     <= 1'b0;
      error_cnt    <= '0;
      i2c_rw       <= 1'b0;
      i2c_reg_addr <= '0;
      i2c_wdata    <= '0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_data  <= '0;
      cfg_en_q     <= 1'b0;
      cfg_en_prev  <= 1'b0;
    end else begin
      entry_idx    <= entry_d;
      retry_cnt    <= retry_d;
      poll_idx     <= poll_idx_d;
      timer        <= timer_d;
      pend         <= pend_d;
      cfg_done     <= cfg_done_d;
      cfg_fail     <= cfg_fail_d;
      error_cnt    <= err_d;
      i2c_rw       <= rw_d;
      i2c_reg_addr <= addr_d;
      i2c_wdata    <= wdata_d;
      sample_valid <= sv_d;
      sample_idx   <= sidx_d;
      sample_data  <= sdata_d;
      cfg_en_q     <= configure_en;
      cfg_en_prev  <= cfg_en_q;
    end
  end

endmodule

// File: tb/tb_accel_cfg_seq.sv
// Scoreboard bench for accel_cfg_seq: a behavioural I2C master answers requests from an expected-transaction queue.
module tb_accel_cfg_seq;

  localparam int         NREGS = 8;
  localparam int         MAXR  = 3;
  localparam int         PDIV  = 100;
  localparam logic [7:0] PBASE = 8'h32;
  localparam int         PLEN  = 6;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       configure_en;
  logic       i2c_req, i2c_rw;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr, i2c_wdata;
  logic       i2c_done, i2c_nack;
  logic [7:0] i2c_rdata;
  logic       cfg_done, cfg_fail;
  logic [7:0] error_cnt;
  logic       sample_valid;
  logic [2:0] sample_idx;
  logic [7:0] sample_data;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       nack;
    logic [7:0] rdata;
    int         start;
  } txn_t;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
  } smp_t;

  txn_t exp_txn[$];
  smp_t exp_smp[$];

  logic [7:0] cfg_addr [NREGS] = '{8'h2D, 8'h31, 8'h2C, 8'h2E, 8'h2F, 8'h38, 8'h1E, 8'h2D};
  logic [7:0] cfg_data [NREGS] = '{8'h00, 8'h0B, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h08};

  int n_compared = 0;
  int n_mismatched = 0;
  int cycle = 0;
  int trigger_cycle = 0;
  int model_err = 0;
  bit exp_done = 0;
  bit exp_fail = 0;
  int m_phase = 0;
  int prev_burst = -1;

  accel_cfg_seq #(
    .NUM_REGS  (NREGS),
    .MAX_RETRY (MAXR),
    .POLL_DIV  (PDIV),
    .POLL_BASE (PBASE),
    .POLL_LEN  (PLEN)
  ) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .configure_en (configure_en),
    .i2c_req      (i2c_req),
    .i2c_rw       (i2c_rw),
    .i2c_dev_addr (i2c_dev_addr),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_wdata    (i2c_wdata),
    .i2c_done     (i2c_done),
    .i2c_nack     (i2c_nack),
    .i2c_rdata    (i2c_rdata),
    .cfg_done     (cfg_done),
    .cfg_fail     (cfg_fail),
    .error_cnt    (error_cnt),
    .sample_valid (sample_valid),
    .sample_idx   (sample_idx),
    .sample_data  (sample_data)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic reportFail(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s (cycle %0d)", name, cycle);
  endtask

  function automatic int satInc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic tick1();
    @(posedge clk_in);
    #1;
  endtask

  // Expected write sequence for one configuration run; nack_entry is NACKed nack_cnt times.
  task automatic pushConfig(input int nack_entry, input int nack_cnt, input bit timed);
    txn_t t;
    bit   first;
    int   n;
    first    = timed;
    exp_done = 0;
    exp_fail = 0;
    for (int e = 0; e < NREGS; e++) begin
      n = (e == nack_entry) ? nack_cnt : 0;
      for (int a = 0; a <= MAXR; a++) begin
        t.rw    = 1'b0;
        t.addr  = cfg_addr[e];
        t.wdata = cfg_data[e];
        t.nack  = (a < n);
        t.rdata = 8'h00;
        t.start = first ? trigger_cycle + 3 : -1;
        first   = 0;
        exp_txn.push_back(t);
        if (!t.nack) break;
        model_err = satInc(model_err);
      end
      if (n > MAXR) begin
        exp_fail = 1;
        return;
      end
    end
    exp_done = 1;
  endtask

  task automatic pushBurst(input int nack_at);
    txn_t t;
    smp_t s;
    for (int i = 0; i < PLEN; i++) begin
      t.rw    = 1'b1;
      t.addr  = PBASE + 8'(i);
      t.wdata = 8'h00;
      t.nack  = (i == nack_at);
      t.rdata = 8'($urandom);
      t.start = -1;
      exp_txn.push_back(t);
      if (t.nack) begin
        model_err = satInc(model_err);
        break;
      end
      s.idx  = 3'(i);
      s.data = t.rdata;
      exp_smp.push_back(s);
    end
  endtask

  task automatic applyStimulus();
    configure_en = 1'b0;
    tick1();
    tick1();
    configure_en = 1'b1;
    trigger_cycle = cycle;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n;
    n = 0;
    while (!(exp_txn.size() == 0 && exp_smp.size() == 0 && m_phase == 0) && n < limit) begin
      tick1();
      n++;
    end
    if (!(exp_txn.size() == 0 && exp_smp.size() == 0 && m_phase == 0)) begin
      reportFail({name, "_timeout"});
      exp_txn.delete();
      exp_smp.delete();
    end
    repeat (3) tick1();
  endtask

  task automatic checkStatus(input string name);
    checkOutput({name, "_cfg_done"}, 32'(cfg_done), 32'(exp_done));
    checkOutput({name, "_cfg_fail"}, 32'(cfg_fail), 32'(exp_fail));
    checkOutput({name, "_error_cnt"}, 32'(error_cnt), 32'(model_err));
  endtask

  // Behavioural master: pops the expected transaction, checks it, answers after a random latency.
  initial begin : master
    txn_t cur;
    int   cnt;
    i2c_done  = 1'b0;
    i2c_nack  = 1'b0;
    i2c_rdata = 8'h00;
    cnt = 0;
    forever begin
      tick1();
      if (m_phase == 2) begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        checkOutput("req_drop_after_done", 32'(i2c_req), 32'd0);
        m_phase = 0;
      end else if (m_phase == 1) begin
        cnt--;
        if (cnt == 0) begin
          checkOutput("req_stable", {14'd0, i2c_req, i2c_rw, i2c_reg_addr},
                      {14'd0, 1'b1, cur.rw, cur.addr});
          i2c_done  = 1'b1;
          i2c_nack  = cur.nack;
          i2c_rdata = cur.rdata;
          m_phase   = 2;
        end
      end else if (i2c_req) begin
        if (exp_txn.size() == 0) begin
          reportFail("unexpected_req");
          cur.rw = i2c_rw; cur.addr = i2c_reg_addr; cur.wdata = i2c_wdata;
          cur.nack = 1'b0; cur.rdata = 8'h00; cur.start = -1;
        end else begin
          cur = exp_txn.pop_front();
          checkOutput("txn_rw_addr", {23'd0, i2c_rw, i2c_reg_addr}, {23'd0, cur.rw, cur.addr});
          if (!cur.rw) checkOutput("txn_wdata", 32'(i2c_wdata), 32'(cur.wdata));
          if (cur.start >= 0) checkOutput("req_latency", 32'(cycle), 32'(cur.start));
          if (!cur.rw) prev_burst = -1;
          else if (cur.addr == PBASE) begin
            if (prev_burst >= 0) checkOutput("poll_period", 32'(cycle - prev_burst), 32'(PDIV));
            prev_burst = cycle;
          end
        end
        cnt = $urandom_range(1, 4);
        m_phase = 1;
      end
    end
  end

  initial begin : sample_monitor
    smp_t s;
    forever begin
      tick1();
      if (sample_valid) begin
        if (exp_smp.size() == 0) reportFail("unexpected_sample");
        else begin
          s = exp_smp.pop_front();
          checkOutput("sample_idx", 32'(sample_idx), 32'(s.idx));
          checkOutput("sample_data", 32'(sample_data), 32'(s.data));
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int extra;
    reset_n      = 1'b0;
    configure_en = 1'b0;
    repeat (3) tick1();
    checkOutput("rst_i2c_req", 32'(i2c_req), 32'd0);
    checkOutput("rst_i2c_rw", 32'(i2c_rw), 32'd0);
    checkOutput("rst_reg_addr", 32'(i2c_reg_addr), 32'd0);
    checkOutput("rst_wdata", 32'(i2c_wdata), 32'd0);
    checkOutput("rst_dev_addr", 32'(i2c_dev_addr), 32'h53);
    checkOutput("rst_cfg_done", 32'(cfg_done), 32'd0);
    checkOutput("rst_cfg_fail", 32'(cfg_fail), 32'd0);
    checkOutput("rst_error_cnt", 32'(error_cnt), 32'd0);
    checkOutput("rst_sample_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_sample_idx", 32'(sample_idx), 32'd0);
    checkOutput("rst_sample_data", 32'(sample_data), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick1();

    $display("[TB] configuration with an always-ACK master, then polling");
    applyStimulus();
    pushConfig(-1, 0, 1);
    pushBurst(-1);
    pushBurst(-1);
    waitDrain("cfg_all_ack", 3000);
    checkStatus("all_ack");

    $display("[TB] entry 3 NACKed twice, poll burst NACKed at byte 2");
    applyStimulus();
    pushConfig(3, 2, 1);
    pushBurst(-1);
    pushBurst(2);
    pushBurst(-1);
    waitDrain("cfg_retry", 5000);
    checkStatus("retry");

    $display("[TB] restart requested in the middle of a poll burst");
    configure_en = 1'b0;
    pushBurst(-1);
    n = 0;
    while (exp_smp.size() > PLEN - 2 && n < 400) begin
      tick1();
      n++;
    end
    if (exp_smp.size() > PLEN - 2) reportFail("mid_burst_wait_timeout");
    configure_en = 1'b1;
    pushConfig(-1, 0, 0);
    pushBurst(-1);
    waitDrain("cfg_mid_burst", 3000);
    checkStatus("mid_burst");

    $display("[TB] entry 0 exhausts its retries, repeated until error_cnt saturates");
    extra = 0;
    while (extra < 2) begin
      applyStimulus();
      pushConfig(0, MAXR + 1, 1);
      waitDrain("cfg_exhaust", 500);
      repeat (5) tick1();
      checkOutput("fail_req_idle", 32'(i2c_req), 32'd0);
      checkStatus("exhaust");
      if (model_err == 255) extra++;
    end

    $display("[TB] restart from the failed state, then a NACKed burst at saturation");
    applyStimulus();
    pushConfig(-1, 0, 1);
    pushBurst(0);
    pushBurst(-1);
    waitDrain("cfg_after_fail", 3000);
    checkStatus("saturated");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
